// File: rtl/tone_meter_pkg.sv
// Shared types and default constants for the tone period meter.
//   state_t            : measurement FSM states
//   CLK_HZ             : nominal system clock frequency
//   DEF_FILT_CYCLES    : default glitch-filter stability length
//   DEF_TIMEOUT_CYCLES : default no-edge timeout (10 ms at 27 MHz)
package tone_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int unsigned CLK_HZ             = 27_000_000;
  localparam int unsigned DEF_FILT_CYCLES    = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 270_000;

endpackage

// File: rtl/glitch_filter.sv
// Input conditioning for the tone pin: 2-FF synchronizer, stability filter
// and a registered one-cycle rising-edge strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous input
//   level      : filtered level
//   rise       : one-cycle strobe after each accepted 0->1 change of level
module glitch_filter
  import tone_meter_pkg::*;
#(
  parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // The count only runs while the synced value disagrees with the accepted
  // level; any return to agreement restarts it, so only an unbroken run of
  // FILT_CYCLES differing cycles flips the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/tone_period_meter.sv
// Measures the period of a square-wave tone in clk cycles and shows the
// result on active-low LEDs.
//   clk, rst_n   : 27 MHz clock, asynchronous active-low reset
//   tone_in      : raw tone input pin
//   btn1         : active-low freeze button (holds the displayed result)
//   period       : last measured period in clk cycles
//   period_valid : one-cycle pulse when period updates
//   tone_present : high while periodic edges keep arriving
//   led          : active-low LEDs {btn1, ~tone_present, ~period slice}
module tone_period_meter
  import tone_meter_pkg::*;
#(
  parameter int unsigned FILT_CYCLES    = DEF_FILT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned PERIOD_W       = 20,
  parameter int unsigned LED_SHIFT      = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tone_in,
  input  logic                btn1,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                tone_present,
  output logic [5:0]          led
);

  localparam logic [PERIOD_W-1:0] TIMEOUT = PERIOD_W'(TIMEOUT_CYCLES);
  localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);

  logic [1:0]          rst_pipe;
  logic                rst_i;
  logic [1:0]          btn_pipe;
  logic                frozen;
  logic                rise;
  logic                level;

  state_t              state;
  state_t              state_n;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cnt_n;
  logic                capture;
  logic                present_n;

  // Assertion clears everything at once; release reaches the core only
  // after two clock edges so all flops leave reset on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= '0;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end
  assign rst_i = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      btn_pipe <= '1;
    end else begin
      btn_pipe <= {btn_pipe[0], btn1};
    end
  end
  assign frozen = ~btn_pipe[1];

  glitch_filter #(
    .FILT_CYCLES (FILT_CYCLES)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_i),
    .din   (tone_in),
    .level (level),
    .rise  (rise)
  );

  // cnt holds the cycles elapsed since the last accepted rise: it restarts
  // at 1 on the cycle after a rise, so on the next rise it equals the period.
  // A rise on the cycle cnt reaches TIMEOUT is therefore still a valid period.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    capture   = 1'b0;
    present_n = tone_present;
    unique case (state)
      IDLE: begin
        present_n = 1'b0;
        cnt_n     = '0;
        if (rise) begin
          state_n = MEASURE;
          cnt_n   = ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          capture   = 1'b1;
          present_n = 1'b1;
          cnt_n     = ONE;
        end else if (cnt >= TIMEOUT) begin
          state_n   = IDLE;
          present_n = 1'b0;
        end else if (cnt != '1) begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n   = IDLE;
        present_n = 1'b0;
        cnt_n     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      tone_present <= 1'b0;
      period_valid <= 1'b0;
      period       <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      tone_present <= present_n;
      period_valid <= capture & ~frozen;
      if (capture && !frozen) begin
        period <= cnt;
      end
    end
  end

  assign led = {btn1, ~tone_present, ~period[LED_SHIFT+3:LED_SHIFT]};

endmodule

// File: tb/tb_tone_period_meter.sv
// Self-checking bench for tone_period_meter (timing constants scaled down).
module tb_tone_period_meter;

  localparam int unsigned FILT = 16;
  localparam int unsigned TMO  = 2700;
  localparam int unsigned PW   = 12;
  localparam int unsigned LSH  = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tone_in = 1'b0;
  logic          btn1 = 1'b1;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          tone_present;
  logic [5:0]    led;

  always #5 clk = ~clk;

  tone_period_meter #(
    .FILT_CYCLES    (FILT),
    .TIMEOUT_CYCLES (TMO),
    .PERIOD_W       (PW),
    .LED_SHIFT      (LSH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tone_in      (tone_in),
    .btn1         (btn1),
    .period       (period),
    .period_valid (period_valid),
    .tone_present (tone_present),
    .led          (led)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the pin is described as a list of constant-level
  // segments. A segment whose level differs from the accepted level and that
  // lasts at least FILT cycles is accepted; accepted rises are timestamped at
  // the segment start (fixed latency cancels in differences). Consecutive
  // rises no further apart than TMO yield a period unless btn1 is low.
  bit     m_filt  = 1'b0;
  bit     m_armed = 1'b0;
  longint t       = 0;
  longint m_last  = 0;
  int     exp_q[$];
  int     mon_e;

  task automatic model_rise();
    if (m_armed && (t - m_last) <= longint'(TMO) && btn1) exp_q.push_back(int'(t - m_last));
    m_armed = 1'b1;
    m_last  = t;
  endtask

  task automatic seg(input bit lvl, input int len);
    tone_in = lvl;
    if (lvl != m_filt && len >= int'(FILT)) begin
      m_filt = lvl;
      if (lvl) model_rise();
    end
    repeat (len) @(posedge clk);
    #1;
    t += len;
  endtask

  function automatic int led_of(input int p);
    return ((p >> LSH) & 15) ^ 15;
  endfunction

  always @(negedge clk) begin
    if (rst_n && period_valid) begin
      chk("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("pulse_period", 32'(period), 32'(mon_e));
        chk("pulse_led", 32'(led[3:0]), 32'(led_of(mon_e)));
        chk("pulse_led5", 32'(led[5]), 32'(btn1));
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_valid", 32'(period_valid), 32'd0);
    chk("rst_present", 32'(tone_present), 32'd0);
    chk("rst_led", 32'(led), 32'({btn1, 5'b11111}));
  endtask

  typedef struct {
    int         half;
    int         reps;
    logic [11:0] exp_period;
    logic [3:0]  exp_led;
  } vec_t;
  vec_t tbl[4];

  int h, l, g, a;

  initial begin
    tbl[0] = '{270,  4, 12'd540,  4'b0111};
    tbl[1] = '{135,  4, 12'd270,  4'b1011};
    tbl[2] = '{300,  3, 12'd600,  4'b0110};
    tbl[3] = '{1350, 2, 12'd2700, 4'b0101};  // gap equals the timeout

    #1;
    check_reset_outputs();
    btn1 = 1'b0;
    #1;
    chk("rst_led_btn_low", 32'(led), 32'(6'b011111));
    btn1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seg(0, 50);

    // First rise only arms
    seg(1, 270);
    seg(0, 270);
    chk("first_edge_period", 32'(period), 32'd0);
    chk("first_edge_present", 32'(tone_present), 32'd0);

    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        seg(1, tbl[i].half);
        seg(0, tbl[i].half);
      end
      chk("tbl_period", 32'(period), 32'(tbl[i].exp_period));
      chk("tbl_led", 32'(led[3:0]), 32'(tbl[i].exp_led));
      chk("tbl_present", 32'(tone_present), 32'd1);
    end

    // Short glitches inside both phases are ignored
    for (int r = 0; r < 3; r++) begin
      seg(1, 100); seg(0, 5); seg(1, 165);
      seg(0, 120); seg(1, int'(FILT) - 1); seg(0, 135);
    end
    chk("glitch_period", 32'(period), 32'd540);

    // A 20-cycle pulse is a real edge
    seg(1, 270); seg(0, 100); seg(1, 20); seg(0, 150); seg(1, 270); seg(0, 100);
    chk("pulse20_period", 32'(period), 32'd170);

    // Tone stops with the line held high
    for (int r = 0; r < 2; r++) begin
      seg(1, 270);
      seg(0, 270);
    end
    seg(1, int'(TMO + FILT) + 1);
    chk("timeout_before", 32'(tone_present), 32'd1);
    seg(1, 6);
    chk("timeout_after", 32'(tone_present), 32'd0);
    chk("timeout_period", 32'(period), 32'd540);
    chk("timeout_led4", 32'(led[4]), 32'd1);
    chk("timeout_led", 32'(led[3:0]), 32'(4'b0111));
    seg(0, 100);

    // Freeze while the tone switches to 1 kHz
    for (int r = 0; r < 3; r++) begin
      seg(1, 270);
      seg(0, 270);
    end
    seg(1, 270);
    btn1 = 1'b0;
    seg(0, 270);
    for (int r = 0; r < 4; r++) begin
      seg(1, 135);
      seg(0, 135);
    end
    chk("freeze_period", 32'(period), 32'd540);
    chk("freeze_led", 32'(led[3:0]), 32'(4'b0111));
    chk("freeze_led5", 32'(led[5]), 32'd0);
    chk("freeze_present", 32'(tone_present), 32'd1);
    seg(1, 135);
    btn1 = 1'b1;
    seg(0, 135);
    seg(1, 135);
    seg(0, 135);
    chk("unfreeze_period", 32'(period), 32'd270);

    // Reset in the middle of a period
    seg(1, 270); seg(0, 270); seg(1, 270); seg(0, 100);
    chk("pre_reset_period", 32'(period), 32'd540);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (4) @(posedge clk);
    #1;
    t += 4;
    rst_n = 1'b1;
    m_filt  = 1'b0;
    m_armed = 1'b0;
    seg(0, 100);
    seg(1, 270);
    seg(0, 270);
    chk("post_reset_first", 32'(period), 32'd0);
    chk("post_reset_present", 32'(tone_present), 32'd0);
    seg(1, 270);
    seg(0, 100);
    chk("post_reset_period", 32'(period), 32'd540);
    chk("post_reset_present2", 32'(tone_present), 32'd1);

    // Randomized waveforms with random glitches, checked by the model
    for (int i = 0; i < 10; i++) begin
      h = int'($urandom_range(FILT, 1400));
      l = int'($urandom_range(FILT, 1400));
      g = int'($urandom_range(1, FILT + 4));
      if ($urandom_range(0, 1) == 1 && h > 2) begin
        a = int'($urandom_range(1, h - 1));
        seg(1, a);
        seg(0, g);
        seg(1, h - a);
      end else begin
        seg(1, h);
      end
      seg(0, l);
    end

    seg(0, 200);
    chk("all_pulses_seen", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
